// File: rtl/if_stage_pkg.sv
// Shared pipeline constants for the fetch stage and its neighbours.
// Holds the bubble encoding, IF state codes, reset PC default and RV32I opcodes.
// Imported by if_stage, if_id_reg and the decode stage.
package if_stage_pkg;

   // Default reset PC and the bubble instruction (addi x0,x0,0).
   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

   // Fetch FSM encoding; code 2'd3 is unused and recovers to FETCH.
   localparam logic [1:0] IF_FETCH = 2'd0;
   localparam logic [1:0] IF_HOLD  = 2'd1;
   localparam logic [1:0] IF_DRAIN = 2'd2;

   // RV32I major opcodes decoded in ID.
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // Contents of the IF/ID pipeline register.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
   } if_id_t;

   // Instruction fetches are always word aligned.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// Pipeline register carrying (PC, instruction, valid) between two stages.
// Latency: one cycle from load to output; flush forces a bubble next cycle.
// No handshake: when neither load nor flush is set the contents are held.
module if_id_reg
   import if_stage_pkg::*;
#(
   parameter int          PC_W      = 32,
   parameter int          INSTR_W   = 32,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic               flush_i,
   input  logic [PC_W-1:0]    pc_i,
   input  logic [INSTR_W-1:0] instr_i,
   input  logic               valid_i,
   output logic [PC_W-1:0]    pc_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic               valid_o
);

   logic [PC_W-1:0]    pc_q;
   logic [INSTR_W-1:0] instr_q;
   logic               valid_q;

   // Flush wins over load; reset and flush both produce a PC-0 bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= '0;
         instr_q <= INSTR_W'(NOP_INSTR);
         valid_q <= 1'b0;
      end else if (flush_i) begin
         pc_q    <= '0;
         instr_q <= INSTR_W'(NOP_INSTR);
         valid_q <= 1'b0;
      end else if (load_i) begin
         pc_q    <= pc_i;
         instr_q <= instr_i;
         valid_q <= valid_i;
      end
   end

   assign pc_o    = pc_q;
   assign instr_o = instr_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, single-outstanding IMEM requests, IF/ID register.
// Latency: an instruction reaches ID the cycle after IMEM_VALID (1/cycle zero-wait).
// STALL_IF holds PC and IF/ID (response parked in hold_buf); PCSrc_EX redirect wins.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        STALL_IF,
   input  logic        PCSrc_EX,
   input  logic [31:0] PC_BRANCH_EX,
   output logic        IMEM_REQ,
   output logic [31:0] IMEM_ADDR,
   input  logic [31:0] IMEM_RDATA,
   input  logic        IMEM_VALID,
   output logic [31:0] PC_ID,
   output logic [31:0] INSTRUCTION_ID,
   output logic        VALID_ID
);

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] hold_buf_q, hold_buf_d;
   logic [31:0] stale_addr_q, stale_addr_d;

   logic        idr_load;
   logic        idr_flush;
   if_id_t      idr_d;

   // Next-state logic: redirect first, then the per-state fetch actions.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      hold_buf_d   = hold_buf_q;
      stale_addr_d = stale_addr_q;
      idr_load     = 1'b0;
      idr_flush    = 1'b0;
      idr_d.pc     = pc_q;
      idr_d.instr  = NOP_INSTR;
      idr_d.valid  = 1'b0;

      if (PCSrc_EX) begin
         pc_d       = word_align(PC_BRANCH_EX);
         idr_flush  = 1'b1;
         hold_buf_d = NOP_INSTR;
         case (state_q)
            IF_FETCH: begin
               // An unanswered request must be drained before refetching.
               if (!IMEM_VALID) begin
                  stale_addr_d = pc_q;
                  state_d      = IF_DRAIN;
               end
            end
            IF_DRAIN: state_d = IF_DRAIN;
            default:  state_d = IF_FETCH;
         endcase
      end else begin
         case (state_q)
            IF_FETCH: begin
               if (IMEM_VALID && !STALL_IF) begin
                  idr_load    = 1'b1;
                  idr_d.instr = IMEM_RDATA;
                  idr_d.valid = 1'b1;
                  pc_d        = pc_q + 32'd4;
               end else if (IMEM_VALID) begin
                  hold_buf_d = IMEM_RDATA;
                  state_d    = IF_HOLD;
               end else if (!STALL_IF) begin
                  // Memory still busy: send a bubble tagged with the fetch PC.
                  idr_load = 1'b1;
               end
            end
            IF_HOLD: begin
               if (!STALL_IF) begin
                  idr_load    = 1'b1;
                  idr_d.instr = hold_buf_q;
                  idr_d.valid = 1'b1;
                  pc_d        = pc_q + 32'd4;
                  state_d     = IF_FETCH;
               end
            end
            IF_DRAIN: begin
               idr_flush = 1'b1;
               if (IMEM_VALID) begin
                  state_d = IF_FETCH;
               end
            end
            default: state_d = IF_FETCH;
         endcase
      end
   end

   // Fetch state, PC, parked response and drained address.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IF_FETCH;
         pc_q         <= word_align(RESET_PC);
         hold_buf_q   <= NOP_INSTR;
         stale_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         hold_buf_q   <= hold_buf_d;
         stale_addr_q <= stale_addr_d;
      end
   end

   // Request is gated by reset directly so it drops the moment reset rises.
   assign IMEM_REQ  = !reset && ((state_q == IF_FETCH) || (state_q == IF_DRAIN));
   assign IMEM_ADDR = (state_q == IF_DRAIN) ? stale_addr_q : pc_q;

   if_id_reg #(
      .PC_W      (32),
      .INSTR_W   (32),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk     (clk),
      .rst     (reset),
      .load_i  (idr_load),
      .flush_i (idr_flush),
      .pc_i    (idr_d.pc),
      .instr_i (idr_d.instr),
      .valid_i (idr_d.valid),
      .pc_o    (PC_ID),
      .instr_o (INSTRUCTION_ID),
      .valid_o (VALID_ID)
   );

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage with a variable-latency memory model.
// Expected instruction stream comes from a transaction-level fetch model.
// A negedge monitor pops the scoreboard whenever a new valid instruction shows up.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        STALL_IF = 1'b0;
   logic        PCSrc_EX = 1'b0;
   logic [31:0] PC_BRANCH_EX = '0;
   logic [31:0] IMEM_RDATA = '0;
   logic        IMEM_VALID = 1'b0;
   logic        IMEM_REQ;
   logic [31:0] IMEM_ADDR;
   logic [31:0] PC_ID;
   logic [31:0] INSTRUCTION_ID;
   logic        VALID_ID;

   if_stage dut (
      .clk            (clk),
      .reset          (reset),
      .STALL_IF       (STALL_IF),
      .PCSrc_EX       (PCSrc_EX),
      .PC_BRANCH_EX   (PC_BRANCH_EX),
      .IMEM_REQ       (IMEM_REQ),
      .IMEM_ADDR      (IMEM_ADDR),
      .IMEM_RDATA     (IMEM_RDATA),
      .IMEM_VALID     (IMEM_VALID),
      .PC_ID          (PC_ID),
      .INSTRUCTION_ID (INSTRUCTION_ID),
      .VALID_ID       (VALID_ID)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   int          tests = 0;
   int          fails = 0;
   exp_t        exp_q[$];
   exp_t        mon_e;

   // Memory and reference-model state.
   bit          busy = 0;
   logic [31:0] m_addr = '0;
   int          m_lat = 0;
   int          m_gen = 0;
   int          gen = 0;
   logic [31:0] next_pc = '0;
   bit          pend = 0;
   exp_t        pend_item;

   // Monitor history.
   bit          prev_valid = 0;
   logic [31:0] prev_pc = '0;
   bit          prev_redir = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a + 32'h0000_1000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock of memory response, hazard stimulus and model update; call at posedge+1.
   task automatic step(input int lat_lo, input int lat_hi, input int stall_pct,
                       input int redir_pct, input bit f_stall, input bit f_redir,
                       input logic [31:0] f_tgt);
      bit          resp;
      exp_t        it;
      logic [31:0] tgt;
      if (!busy && IMEM_REQ) begin
         chk("req_addr", IMEM_ADDR, next_pc);
         busy   = 1;
         m_addr = IMEM_ADDR;
         m_lat  = int'($urandom_range(lat_hi, lat_lo));
         m_gen  = gen;
      end else if (busy) begin
         chk("req_held", {31'b0, IMEM_REQ}, 32'd1);
         chk("addr_held", IMEM_ADDR, m_addr);
      end
      resp = busy && (m_lat == 0);
      if (busy && m_lat > 0) m_lat--;
      IMEM_VALID = resp;
      IMEM_RDATA = resp ? mem_word(m_addr) : 32'hDEAD_BEEF;
      STALL_IF   = f_stall || (int'($urandom_range(99, 0)) < stall_pct);
      tgt        = f_redir ? f_tgt : ($urandom & 32'h0000_FFFF);
      // Never redirect on the beat a discarded response returns.
      PCSrc_EX     = (f_redir || (int'($urandom_range(99, 0)) < redir_pct)) && (!resp || m_gen == gen);
      PC_BRANCH_EX = tgt;
      if (PCSrc_EX) begin
         gen++;
         next_pc = tgt & ~32'd3;
         pend    = 0;
      end
      if (resp) begin
         busy = 0;
         if (m_gen == gen) begin
            it.pc    = m_addr;
            it.instr = mem_word(m_addr);
            next_pc  = next_pc + 32'd4;
            if (STALL_IF) begin
               pend      = 1;
               pend_item = it;
            end else begin
               exp_q.push_back(it);
            end
         end
      end else if (pend && !STALL_IF && !PCSrc_EX) begin
         exp_q.push_back(pend_item);
         pend = 0;
      end
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: checks redirect bubbles and each newly presented instruction.
   always @(negedge clk) begin
      if (reset) begin
         prev_valid = 0;
         prev_pc    = '0;
         prev_redir = 0;
      end else begin
         if (prev_redir) begin
            chk("redir_bubble_valid", {31'b0, VALID_ID}, 32'd0);
            chk("redir_bubble_pc", PC_ID, 32'd0);
            chk("redir_bubble_instr", INSTRUCTION_ID, NOP);
         end else if (VALID_ID && (!prev_valid || PC_ID != prev_pc)) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_instr_pc", PC_ID, 32'hFFFF_FFFF);
            end else begin
               mon_e = exp_q.pop_front();
               chk("id_pc", PC_ID, mon_e.pc);
               chk("id_instr", INSTRUCTION_ID, mon_e.instr);
            end
         end
         prev_valid = VALID_ID;
         prev_pc    = PC_ID;
         prev_redir = PCSrc_EX;
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   // Directed sequences from the test plan, then a long randomized run.
   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_req", {31'b0, IMEM_REQ}, 32'd0);
      chk("reset_pc_id", PC_ID, 32'd0);
      chk("reset_instr", INSTRUCTION_ID, NOP);
      chk("reset_valid", {31'b0, VALID_ID}, 32'd0);
      next_pc = 32'd0;
      reset   = 1'b0;

      // Zero-wait streaming, then two-cycle memory.
      repeat (12) step(0, 0, 0, 0, 0, 0, 32'd0);
      repeat (12) step(1, 1, 0, 0, 0, 0, 32'd0);

      // Stall in the response cycle, held: no requests while parked.
      step(0, 0, 0, 0, 1, 0, 32'd0);
      repeat (3) begin
         chk("hold_no_req", {31'b0, IMEM_REQ}, 32'd0);
         step(0, 0, 0, 0, 1, 0, 32'd0);
      end
      repeat (4) step(0, 0, 0, 0, 0, 0, 32'd0);

      // Redirect while a slow request is pending: drained, then fetch at target.
      step(3, 3, 0, 0, 0, 0, 32'd0);
      step(0, 0, 0, 0, 0, 1, 32'h0000_0100);
      repeat (8) step(0, 0, 0, 0, 0, 0, 32'd0);

      // Redirect and stall together while parked in HOLD, unaligned target.
      step(0, 0, 0, 0, 1, 0, 32'd0);
      step(0, 0, 0, 0, 1, 1, 32'h0000_0203);
      chk("hold_redir_addr", IMEM_ADDR, 32'h0000_0200);
      repeat (4) step(0, 0, 0, 0, 0, 0, 32'd0);

      // PC wrap at the top of the address space.
      step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFF8);
      repeat (2) step(0, 0, 0, 0, 0, 0, 32'd0);
      chk("wrap_addr", IMEM_ADDR, 32'd0);
      repeat (4) step(0, 0, 0, 0, 0, 0, 32'd0);

      // Random latency, stalls and redirects.
      repeat (3000) step(0, 3, 20, 5, 0, 0, 32'd0);
      repeat (10) step(0, 0, 0, 0, 0, 0, 32'd0);

      // Async reset while draining a stale request.
      step(4, 4, 0, 0, 0, 0, 32'd0);
      step(0, 0, 0, 0, 0, 1, 32'h0000_0040);
      chk("drain_req", {31'b0, IMEM_REQ}, 32'd1);
      step(0, 0, 0, 0, 0, 0, 32'd0);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_req", {31'b0, IMEM_REQ}, 32'd0);
      chk("arst_valid", {31'b0, VALID_ID}, 32'd0);
      chk("arst_instr", INSTRUCTION_ID, NOP);
      chk("arst_pc", PC_ID, 32'd0);
      busy       = 0;
      pend       = 0;
      exp_q.delete();
      next_pc    = 32'd0;
      gen++;
      IMEM_VALID = 1'b0;
      PCSrc_EX   = 1'b0;
      STALL_IF   = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (12) step(0, 0, 0, 0, 0, 0, 32'd0);

      @(negedge clk);
      #1;
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage RISC-V pipeline, directly upstream of the ID stage.
- Holds the program counter and issues requests to a variable-latency instruction memory (at most one request outstanding).
- Handles load-use stalls and taken-branch redirects from EX.
- Contains the IF/ID pipeline register that drives PC_ID and INSTRUCTION_ID into ID.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
NOP_INSTR, 32'h00000013, instruction inserted as a bubble (addi x0,x0,0).

Ports:
clk  input  1  clock, all state updates on rising edge.
reset  input  1  asynchronous reset, active-high.
STALL_IF  input  1  hazard unit hold request: keep PC and IF/ID unchanged.
PCSrc_EX  input  1  taken branch/jump resolved in EX.
PC_BRANCH_EX  input  32  redirect target.
IMEM_REQ  output  1  fetch request valid.
IMEM_ADDR  output  32  fetch word address; bits [1:0] always 00.
IMEM_RDATA  input  32  instruction data, meaningful only when IMEM_VALID=1.
IMEM_VALID  input  1  response for the current request. May be high in the same cycle as IMEM_REQ (zero-wait memory).
PC_ID  output  32  IF/ID register: PC of the instruction.
INSTRUCTION_ID  output  32  IF/ID register: instruction word.
VALID_ID  output  1  IF/ID register: 1 = real instruction, 0 = bubble.

Behaviour:
- Reset (async, any state):
  - PC_IF=RESET_PC, state=FETCH, hold buffer cleared.
  - PC_ID=0, INSTRUCTION_ID=NOP_INSTR, VALID_ID=0.
  - IMEM_REQ=0 while reset is high.
- States: FETCH, HOLD, DRAIN. Encoded in 2 bits; the unused code returns to FETCH.
- FETCH: IMEM_REQ=1, IMEM_ADDR=PC_IF.
  - IMEM_VALID=1, STALL_IF=0 -> IF/ID<={PC_IF, IMEM_RDATA, 1}; PC_IF<=PC_IF+4.
  - IMEM_VALID=1, STALL_IF=1 -> hold_buf<=IMEM_RDATA; go HOLD. PC_IF and IF/ID unchanged.
  - IMEM_VALID=0, STALL_IF=0 -> IF/ID<={PC_IF, NOP_INSTR, 0} (bubble); PC_IF unchanged.
  - IMEM_VALID=0, STALL_IF=1 -> all unchanged.
- HOLD: IMEM_REQ=0.
  - STALL_IF=0 -> IF/ID<={PC_IF, hold_buf, 1}; PC_IF<=PC_IF+4; go FETCH.
  - STALL_IF=1 -> all unchanged.
- DRAIN: a stale request is outstanding.
  - IMEM_REQ=1; IMEM_ADDR=stale_addr, held stable until IMEM_VALID.
  - IF/ID = bubble every cycle.
  - IMEM_VALID=1 -> response discarded; go FETCH.
- Redirect (PCSrc_EX=1) has priority over STALL_IF and over all state actions:
  - PC_IF<=PC_BRANCH_EX with bits [1:0] forced to 00.
  - IF/ID<={0, NOP_INSTR, 0}; hold_buf is invalidated.
  - In FETCH with IMEM_VALID=0: stale_addr<=PC_IF; go DRAIN.
  - In FETCH with IMEM_VALID=1, or in HOLD: go FETCH (the response is dropped).
  - In DRAIN: stay DRAIN, stale_addr unchanged, PC_IF updated.
- Latency: zero-wait memory delivers 1 instruction/cycle; an instruction appears on the IF/ID outputs the cycle after IMEM_VALID.
- PC arithmetic: 32-bit wrap, 32'hFFFFFFFC+4 = 32'h00000000.
- IMEM_ADDR/IMEM_REQ must not change while a request is pending (REQ=1, VALID=0) except by moving to DRAIN, which keeps the same address.

Decomposition:
- Shared package (pipeline constants):
  - NOP_INSTR value.
  - if-state encoding (FETCH=2'd0, HOLD=2'd1, DRAIN=2'd2).
  - RESET_PC default.
  - Opcode constants already used by ID.
- Sub-module if_id_reg: 65-bit register (PC, instruction, valid) with load, hold and flush-to-bubble controls, async active-high reset to bubble. Reused by other pipeline registers with width changes.

Test Plan:
1. Reset release, IMEM_VALID tied 1, memory returns addr+32'h1000 -> PC_ID=0,4,8 on consecutive cycles, INSTRUCTION_ID=1000,1004,1008, VALID_ID=1 from the 2nd cycle after reset.
2. Memory with 2-cycle latency -> IMEM_ADDR stable for 2 cycles per fetch; VALID_ID pattern 0,1,0,1; PC_ID sequence 0,4,8.
3. STALL_IF=1 in the cycle IMEM_VALID=1 at PC=0x8, held 3 cycles -> IMEM_REQ=0 and IF/ID unchanged for 3 cycles. After release: PC_ID=0x8 with the buffered instruction, next IMEM_ADDR=0xC.
4. PCSrc_EX=1, PC_BRANCH_EX=0x100 while a request to 0x10 is pending -> IMEM_ADDR stays 0x10 until VALID; that data never reaches ID. Next request is 0x100; first valid PC_ID=0x100.
5. PCSrc_EX=1 and STALL_IF=1 in the same cycle during HOLD, target 0x203 -> redirect wins; VALID_ID=0; next IMEM_ADDR=0x200.
6. PC at 0xFFFFFFFC, zero-wait -> next IMEM_ADDR=0x0. Assert reset mid-DRAIN -> IMEM_REQ=0 and IF/ID=bubble immediately (async). After release, fetch starts at RESET_PC.
